// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache memory bridge.
package icache_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF  = 32;

  // Bridge FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  // AXI read response codes.
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  // Instruction fetch, secure, unprivileged.
  localparam logic [2:0] ARPROT_INSTR = 3'b100;

  // RISC-V NOP (addi x0, x0, 0), a harmless word to hand back on error.
  localparam logic [31:0] ERR_DATA_DEF = 32'h0000_0013;

  // Any response other than OKAY is treated as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RRESP_OKAY;
  endfunction

endpackage

// File: rtl/icache_mem_bridge_if.sv
// Cache-side fill handshake plus AXI4-Lite AR/R channels of the bridge.
interface icache_mem_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  // Cache controller side
  logic                  MEM_READ_REQ;
  logic [ADDR_WIDTH-1:0] MEM_ADDRESS;
  logic                  MEM_BUSYWAIT;
  logic [DATA_WIDTH-1:0] MEM_READDATA;
  logic                  MEM_READDATA_VALID;
  logic                  MEM_ERROR;

  // AXI4-Lite read address / read data channels
  logic                  ARVALID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARREADY;
  logic                  RVALID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RREADY;

  // Bridge view: serves the cache, masters the AXI read channels.
  modport master (
    input  MEM_READ_REQ, MEM_ADDRESS, ARREADY, RVALID, RDATA, RRESP,
    output MEM_BUSYWAIT, MEM_READDATA, MEM_READDATA_VALID, MEM_ERROR,
    output ARVALID, ARADDR, ARPROT, RREADY
  );

  // Environment view: cache controller plus memory/interconnect.
  modport slave (
    output MEM_READ_REQ, MEM_ADDRESS, ARREADY, RVALID, RDATA, RRESP,
    input  MEM_BUSYWAIT, MEM_READDATA, MEM_READDATA_VALID, MEM_ERROR,
    input  ARVALID, ARADDR, ARPROT, RREADY
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic at_max_c;

  assign at_max_c = (count == {WIDTH{1'b1}});

  // Count qualifying cycles until saturated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !at_max_c) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/icache_mem_bridge.sv
// Single-outstanding bridge from the I-cache miss-fill handshake to an
// AXI4-Lite read master. Fill data is registered and held after the valid
// pulse; error responses are replaced with a safe instruction word.
module icache_mem_bridge
  import icache_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned            DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0]  ERR_DATA   = DATA_WIDTH'(ERR_DATA_DEF),
  parameter int unsigned            CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  icache_mem_bridge_if.master   bus,
  output logic [CNT_WIDTH-1:0]  STAT_FILLS,
  output logic [CNT_WIDTH-1:0]  STAT_STALL
);

  state_t                state_q, state_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  rready_q, rready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  fill_inc;
  logic                  stall_inc;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered AXI and cache-side outputs; reset drops AR/R handshakes at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    valid_d   = 1'b0;
    error_d   = error_q;
    fill_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.MEM_READ_REQ) begin
          araddr_d  = bus.MEM_ADDRESS;
          arvalid_d = 1'b1;
          fill_inc  = 1'b1;
          state_d   = ADDR;
        end
      end

      ADDR: begin
        // R is not looked at here: RREADY stays low until AR completes.
        if (bus.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (bus.RVALID) begin
          rdata_d  = resp_is_err(bus.RRESP) ? ERR_DATA : bus.RDATA;
          error_d  = error_q | resp_is_err(bus.RRESP);
          rready_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Busy whenever a fill is in flight; decoded straight from state.
  assign bus.MEM_BUSYWAIT       = (state_q != IDLE);
  assign bus.MEM_READDATA       = rdata_q;
  assign bus.MEM_READDATA_VALID = valid_q;
  assign bus.MEM_ERROR          = error_q;
  assign bus.ARVALID            = arvalid_q;
  assign bus.ARADDR             = araddr_q;
  assign bus.ARPROT             = ARPROT_INSTR;
  assign bus.RREADY             = rready_q;

  assign stall_inc = (state_q != IDLE);

  // Accepted fill requests.
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_fill_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (fill_inc),
    .count   (STAT_FILLS)
  );

  // Cycles the cache is held off.
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .count   (STAT_STALL)
  );

endmodule

// File: tb/tb_icache_mem_bridge.sv
// Self-checking bench for icache_mem_bridge. A second instance with 4-bit
// counters mirrors the same traffic to exercise counter saturation.
module tb_icache_mem_bridge;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] stat_fills, stat_stall;
  logic [3:0]  fills4, stall4;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state
  int          m_fills;
  int          m_stall;
  logic        m_err;
  logic [31:0] m_data;

  icache_mem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bi ();
  icache_mem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bs ();

  assign bs.MEM_READ_REQ = bi.MEM_READ_REQ;
  assign bs.MEM_ADDRESS  = bi.MEM_ADDRESS;
  assign bs.ARREADY      = bi.ARREADY;
  assign bs.RVALID       = bi.RVALID;
  assign bs.RDATA        = bi.RDATA;
  assign bs.RRESP        = bi.RRESP;

  icache_mem_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ERR_DATA   (32'h0000_0013),
    .CNT_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bi.master),
    .STAT_FILLS (stat_fills),
    .STAT_STALL (stat_stall)
  );

  icache_mem_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ERR_DATA   (32'h0000_0013),
    .CNT_WIDTH  (4)
  ) dut_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bs.master),
    .STAT_FILLS (fills4),
    .STAT_STALL (stall4)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    bi.MEM_READ_REQ = 1'b0; bi.MEM_ADDRESS = '0;
    bi.ARREADY = 1'b0; bi.RVALID = 1'b0; bi.RDATA = '0; bi.RRESP = RRESP_OKAY;
    m_fills = 0; m_stall = 0; m_err = 1'b0; m_data = '0;
    @(negedge clk);
    bi.MEM_READ_REQ = 1'b1; bi.MEM_ADDRESS = 32'hCAFE_0000;
    @(negedge clk);
    checks++; if (bi.MEM_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b expected 0", bi.MEM_BUSYWAIT); end
    checks++; if (bi.ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", bi.ARVALID); end
    checks++; if (bi.RREADY !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b expected 0", bi.RREADY); end
    checks++; if (bi.ARADDR !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", bi.ARADDR); end
    checks++; if (bi.MEM_READDATA !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", bi.MEM_READDATA); end
    checks++; if (bi.MEM_READDATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bi.MEM_READDATA_VALID); end
    checks++; if (bi.MEM_ERROR !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bi.MEM_ERROR); end
    checks++; if (bi.ARPROT !== 3'b100) begin errors++; $display("FAIL arprot: got %b expected 100", bi.ARPROT); end
    checks++; if (stat_fills !== 32'h0) begin errors++; $display("FAIL reset_fills: got %0d expected 0", stat_fills); end
    checks++; if (stat_stall !== 32'h0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stat_stall); end
    checks++; if (stall4 !== 4'h0) begin errors++; $display("FAIL reset_stall4: got %0d expected 0", stall4); end
    bi.MEM_READ_REQ = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bi.MEM_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL idle_busywait: got %b expected 0", bi.MEM_BUSYWAIT); end
  endtask

  // One fill. Handshake on AR after ar_wait stall cycles, on R after r_wait.
  // chain_in: REQ was already presented in the current cycle by the previous
  // fill. chain_out: keep REQ high with next_addr throughout this fill.
  task automatic do_fill(input logic [31:0] addr, input int ar_wait, input int r_wait,
                         input logic [31:0] data, input logic [1:0] resp,
                         input bit chain_in, input bit chain_out,
                         input logic [31:0] next_addr, input bit early_r);
    int          lat;
    int          ar_hs;
    int          r_hs;
    logic [31:0] exp_data;
    logic        exp_err;
    lat      = 3 + ar_wait + r_wait;
    ar_hs    = 1 + ar_wait;
    r_hs     = 2 + ar_wait + r_wait;
    exp_data = (resp == RRESP_OKAY) ? data : 32'h0000_0013;
    exp_err  = m_err | (resp != RRESP_OKAY);

    if (!chain_in) @(negedge clk);
    bi.MEM_READ_REQ = 1'b1; bi.MEM_ADDRESS = addr;
    bi.ARREADY = 1'b0; bi.RVALID = 1'b0;
    checks++; if (bi.MEM_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL accept_busywait: got %b expected 0", bi.MEM_BUSYWAIT); end

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      bi.MEM_READ_REQ = chain_out;
      bi.MEM_ADDRESS  = chain_out ? next_addr : 32'($urandom);
      bi.ARREADY = (c == ar_hs) || (c > ar_hs && $urandom_range(0, 1) == 1);
      bi.RVALID  = (c == r_hs) || (early_r && c <= ar_hs);
      bi.RDATA   = (c == r_hs) ? data : 32'($urandom);
      bi.RRESP   = (c == r_hs) ? resp : 2'($urandom);
      checks++; if (bi.MEM_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL busywait c=%0d: got %b expected 1", c, bi.MEM_BUSYWAIT); end
      checks++; if (bi.ARVALID !== (c <= ar_hs)) begin errors++; $display("FAIL arvalid c=%0d: got %b expected %b", c, bi.ARVALID, (c <= ar_hs)); end
      if (c <= ar_hs) begin
        checks++; if (bi.ARADDR !== addr) begin errors++; $display("FAIL araddr c=%0d: got %h expected %h", c, bi.ARADDR, addr); end
      end
      checks++; if (bi.RREADY !== (c > ar_hs && c <= r_hs)) begin errors++; $display("FAIL rready c=%0d: got %b expected %b", c, bi.RREADY, (c > ar_hs && c <= r_hs)); end
      checks++; if (bi.MEM_READDATA_VALID !== (c == lat)) begin errors++; $display("FAIL valid c=%0d: got %b expected %b", c, bi.MEM_READDATA_VALID, (c == lat)); end
      checks++; if (bi.MEM_READDATA !== ((c == lat) ? exp_data : m_data)) begin errors++; $display("FAIL readdata c=%0d: got %h expected %h", c, bi.MEM_READDATA, ((c == lat) ? exp_data : m_data)); end
      if (c == lat) begin
        checks++; if (bi.MEM_ERROR !== exp_err) begin errors++; $display("FAIL error_at_valid: got %b expected %b", bi.MEM_ERROR, exp_err); end
      end
    end

    m_fills++;
    m_stall += lat;
    m_err  = exp_err;
    m_data = exp_data;

    @(negedge clk);
    bi.MEM_READ_REQ = chain_out; bi.MEM_ADDRESS = next_addr;
    bi.ARREADY = 1'b0; bi.RVALID = 1'b0;
    checks++; if (bi.MEM_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL post_busywait: got %b expected 0", bi.MEM_BUSYWAIT); end
    checks++; if (bi.MEM_READDATA_VALID !== 1'b0) begin errors++; $display("FAIL post_valid: got %b expected 0", bi.MEM_READDATA_VALID); end
    checks++; if (bi.ARVALID !== 1'b0 || bi.RREADY !== 1'b0) begin errors++; $display("FAIL post_axi: got arvalid=%b rready=%b expected 0 0", bi.ARVALID, bi.RREADY); end
    checks++; if (bi.MEM_READDATA !== m_data) begin errors++; $display("FAIL post_readdata_hold: got %h expected %h", bi.MEM_READDATA, m_data); end
    checks++; if (bi.MEM_ERROR !== m_err) begin errors++; $display("FAIL post_error: got %b expected %b", bi.MEM_ERROR, m_err); end
    checks++; if (stat_fills !== 32'(m_fills)) begin errors++; $display("FAIL stat_fills: got %0d expected %0d", stat_fills, m_fills); end
    checks++; if (stat_stall !== 32'(m_stall)) begin errors++; $display("FAIL stat_stall: got %0d expected %0d", stat_stall, m_stall); end
    checks++; if (fills4 !== sat4(m_fills)) begin errors++; $display("FAIL stat_fills4: got %0d expected %0d", fills4, sat4(m_fills)); end
    checks++; if (stall4 !== sat4(m_stall)) begin errors++; $display("FAIL stat_stall4: got %0d expected %0d", stall4, sat4(m_stall)); end
    checks++; if (bs.MEM_READDATA !== m_data) begin errors++; $display("FAIL small_readdata: got %h expected %h", bs.MEM_READDATA, m_data); end
  endtask

  task automatic test_min_latency();
    do_fill(32'h0000_0040, 0, 0, 32'hDEAD_BEEF, RRESP_OKAY, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_delayed();
    do_fill(32'h0000_1F00, 4, 2, 32'hA5A5_0F0F, RRESP_OKAY, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_error_resp();
    do_fill(32'h0000_2000, 1, 1, 32'h1234_5678, RRESP_SLVERR, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fill(32'h0000_2004, 0, 2, 32'h0BAD_F00D, RRESP_OKAY,   1'b0, 1'b0, 32'h0, 1'b0);
    do_fill(32'h0000_2008, 2, 0, 32'h7777_7777, RRESP_DECERR, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_fill(32'h0000_3000, 1, 0, 32'h1111_2222, RRESP_OKAY, 1'b0, 1'b1, 32'h0000_3010, 1'b0);
    do_fill(32'h0000_3010, 0, 1, 32'h3333_4444, RRESP_OKAY, 1'b1, 1'b0, 32'h0,         1'b0);
  endtask

  task automatic test_early_rvalid();
    do_fill(32'h0000_4000, 3, 1, 32'h5555_6666, RRESP_OKAY, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    bit          chain;
    bit          nchain;
    logic [31:0] addr;
    logic [31:0] naddr;
    logic [1:0]  resp;
    chain = 1'b0;
    addr  = 32'($urandom);
    for (int t = 0; t < 40; t++) begin
      nchain = (t != 39) && ($urandom_range(0, 2) == 0);
      naddr  = 32'($urandom);
      resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : RRESP_OKAY;
      do_fill(addr, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 32'($urandom),
              resp, chain, nchain, naddr, ($urandom_range(0, 3) == 0));
      chain = nchain;
      addr  = naddr;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bi.MEM_READ_REQ = 1'b1; bi.MEM_ADDRESS = 32'h0000_5000;
    @(negedge clk);
    bi.MEM_READ_REQ = 1'b0; bi.ARREADY = 1'b1;
    @(negedge clk);
    bi.ARREADY = 1'b0; bi.RVALID = 1'b0;
    checks++; if (bi.RREADY !== 1'b1) begin errors++; $display("FAIL mid_rready_before_reset: got %b expected 1", bi.RREADY); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bi.ARVALID !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b expected 0", bi.ARVALID); end
    checks++; if (bi.RREADY !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b expected 0", bi.RREADY); end
    checks++; if (bi.MEM_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL rst_busywait: got %b expected 0", bi.MEM_BUSYWAIT); end
    checks++; if (stat_fills !== 32'h0) begin errors++; $display("FAIL rst_fills: got %0d expected 0", stat_fills); end
    checks++; if (stat_stall !== 32'h0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", stat_stall); end
    checks++; if (stall4 !== 4'h0) begin errors++; $display("FAIL rst_stall4: got %0d expected 0", stall4); end
    checks++; if (bi.MEM_ERROR !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", bi.MEM_ERROR); end
    m_fills = 0; m_stall = 0; m_err = 1'b0; m_data = '0;
    @(negedge clk);
    reset_n = 1'b1;
    bi.RVALID = 1'b1; bi.RDATA = 32'hFEED_FACE; bi.RRESP = RRESP_OKAY;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (bi.MEM_READDATA_VALID !== 1'b0) begin errors++; $display("FAIL lost_req_valid c=%0d: got %b expected 0", c, bi.MEM_READDATA_VALID); end
      checks++; if (bi.MEM_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL lost_req_busy c=%0d: got %b expected 0", c, bi.MEM_BUSYWAIT); end
      checks++; if (bi.MEM_READDATA !== 32'h0) begin errors++; $display("FAIL lost_req_data c=%0d: got %h expected 0", c, bi.MEM_READDATA); end
    end
    bi.RVALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_min_latency();
    test_delayed();
    test_error_resp();
    test_back_to_back();
    test_early_rvalid();
    test_random();
    test_reset_mid();
    test_min_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
